// File: rtl/receiver.sv
// receiver: 8N1 UART receiver with 2-flop input synchronizer.
// Frame: 1 start bit (0), 8 data bits LSB first, stop bit (1).
// SIGNAL_DURATION is clock cycles per bit minus one.
// Optional build macro RX_MAJORITY_VOTE_EN: when defined, each bit is the
// 2-of-3 majority of the synchronized line around the nominal sample point,
// decided one cycle after it; otherwise a single sample is taken.
module receiver #(
    parameter int unsigned SIGNAL_DURATION = 289
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       data_ready,
    output logic       framing_error,
    output logic       busy
);
    localparam int unsigned BYTE = 8;
    localparam int unsigned HALF = SIGNAL_DURATION / 2;
    localparam int unsigned CW   = $clog2(SIGNAL_DURATION + 1);

    localparam logic [CW-1:0] HALF_C = CW'(HALF);
    localparam logic [CW-1:0] FULL_C = CW'(SIGNAL_DURATION);
    localparam logic [2:0]    LAST_C = 3'(BYTE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            dr_q, dr_d;
    logic            fe_q, fe_d;
    logic            busy_q, busy_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            rxs_prev_q, rxs_prev_d;
`ifdef RX_MAJORITY_VOTE_EN
    logic            vote_a_q, vote_a_d;
    logic            vote_b_q, vote_b_d;
    logic            vote_pend_q, vote_pend_d;
`endif

    logic            rxs;
    logic            fall;
    logic            sample_now;
    logic            decide;
    logic            bit_val;
    logic [CW-1:0]   target;

    assign rxs  = sync2_q;
    assign fall = rxs_prev_q & ~rxs;

    // Sample-point timing and bit decision (single sample or delayed 2-of-3 vote)
    always_comb begin
        target     = (state_q == START) ? HALF_C : FULL_C;
        sample_now = (state_q != IDLE) && (cnt_q == target);
`ifdef RX_MAJORITY_VOTE_EN
        // Counter is still cleared at the nominal point; the decision lags by one cycle
        decide     = vote_pend_q;
        bit_val    = (vote_a_q & vote_b_q) | (vote_a_q & rxs) | (vote_b_q & rxs);
        vote_a_d   = rxs_prev_q;
        vote_b_d   = rxs;
        vote_pend_d = sample_now;
`else
        decide     = sample_now;
        bit_val    = rxs;
`endif
    end

    // Next-state logic for the frame FSM, counters and outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        dr_d       = 1'b0;
        fe_d       = 1'b0;
        sync1_d    = RxD;
        sync2_d    = sync1_q;
        rxs_prev_d = rxs;

        if (state_q != IDLE) begin
            cnt_d = sample_now ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d   = START;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (decide) begin
                    state_d   = bit_val ? IDLE : DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d   = {bit_val, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_C) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                    end
                end
            end
            STOP: begin
                if (decide) begin
                    state_d = IDLE;
                    if (bit_val) begin
                        data_d = shift_q;
                        dr_d   = 1'b1;
                    end else begin
                        fe_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            dr_q       <= 1'b0;
            fe_q       <= 1'b0;
            busy_q     <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rxs_prev_q <= 1'b1;
`ifdef RX_MAJORITY_VOTE_EN
            vote_a_q    <= 1'b1;
            vote_b_q    <= 1'b1;
            vote_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            dr_q       <= dr_d;
            fe_q       <= fe_d;
            busy_q     <= busy_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            rxs_prev_q <= rxs_prev_d;
`ifdef RX_MAJORITY_VOTE_EN
            vote_a_q    <= vote_a_d;
            vote_b_q    <= vote_b_d;
            vote_pend_q <= vote_pend_d;
`endif
        end
    end

    assign RxD_data      = data_q;
    assign data_ready    = dr_q;
    assign framing_error = fe_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_receiver.sv
// tb_receiver: directed and randomized frames against a frame-level model.
module tb_receiver;
    localparam int BIT_T  = 290;
    localparam int HALF_T = 144;

    logic       clk = 1'b0;
    logic       rst;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       data_ready;
    logic       framing_error;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    int         dr_cnt = 0;
    int         fe_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] last_dr_val = 8'h00;

    logic [7:0] exp_data;
    int         exp_dr;
    int         exp_fe;

    receiver #(.SIGNAL_DURATION(289)) dut (
        .clk(clk),
        .rst(rst),
        .RxD(RxD),
        .RxD_data(RxD_data),
        .data_ready(data_ready),
        .framing_error(framing_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_ready) begin
            dr_cnt++;
            last_dr_val = RxD_data;
        end
        if (framing_error) fe_cnt++;
        if (data_ready && framing_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        RxD = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame: start, 8 data bits, first stop = stop_val, remaining stops high, then gap.
    // spike_mask inverts the line for one clock at each chosen data bit's sample point.
    // rst_bit >= 0 pulses rst for one clock inside that data bit.
    task automatic send_frame(input logic [7:0] b, input int nstop, input logic stop_val,
                              input logic [7:0] spike_mask, input int rst_bit, input int gap);
        logic v;
        logic sp;
        for (int s = 0; s < 9 + nstop; s++) begin
            if (s == 0) v = 1'b0;
            else if (s <= 8) v = b[s-1];
            else if (s == 9) v = stop_val;
            else v = 1'b1;
            for (int c = 0; c < BIT_T; c++) begin
                sp = (s >= 1) && (s <= 8) && spike_mask[(s >= 1 && s <= 8) ? s-1 : 0] && (c == HALF_T + 1);
                RxD = sp ? ~v : v;
                rst = (rst_bit >= 0) && (s == rst_bit + 1) && (c == 100);
                if ((rst_bit >= 0) && (s == rst_bit + 1) && (c == 101)) begin
                    check("rst_mid_data", {24'd0, RxD_data}, 32'h0);
                    check("rst_mid_dr", {31'd0, data_ready}, 32'd0);
                    check("rst_mid_fe", {31'd0, framing_error}, 32'd0);
                    check("rst_mid_busy", {31'd0, busy}, 32'd0);
                end
                @(posedge clk);
                #1;
            end
        end
        rst = 1'b0;
        idle(gap);
    endtask

    // Frame-level reference: a good frame updates the held byte, a bad stop bit only flags
    task automatic model_frame(input logic [7:0] b, input logic stop_val);
        if (stop_val) begin
            exp_dr++;
            exp_data = b;
        end else begin
            exp_fe++;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_dr"}, dr_cnt, exp_dr);
        check({tag, "_fe"}, fe_cnt, exp_fe);
        check({tag, "_data"}, {24'd0, RxD_data}, {24'd0, exp_data});
        check({tag, "_both"}, both_cnt, 0);
    endtask

    initial begin
        logic [7:0] b;
        logic       sv;
        int         ns;
        int         gap;

        rst = 1'b1;
        RxD = 1'b1;
        exp_data = 8'h00;
        exp_dr = 0;
        exp_fe = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", {24'd0, RxD_data}, 32'h0);
        check("reset_dr", {31'd0, data_ready}, 32'd0);
        check("reset_fe", {31'd0, framing_error}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle(20);

        // 0x55 with two stop bits
        send_frame(8'h55, 2, 1'b1, 8'h00, -1, 10);
        model_frame(8'h55, 1'b1);
        check_state("f55");
        check("f55_last", {24'd0, last_dr_val}, 32'h55);

        // back-to-back 0xA3, 0x0F with one stop bit
        send_frame(8'hA3, 1, 1'b1, 8'h00, -1, 0);
        model_frame(8'hA3, 1'b1);
        check("fA3_last", {24'd0, last_dr_val}, 32'hA3);
        send_frame(8'h0F, 1, 1'b1, 8'h00, -1, 10);
        model_frame(8'h0F, 1'b1);
        check_state("f0F");
        check("f0F_last", {24'd0, last_dr_val}, 32'h0F);

        // 50-clock low glitch while idle: false start
        RxD = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
        end
        check("glitch_busy_hi", {31'd0, busy}, 32'd1);
        idle(200);
        check("glitch_busy_lo", {31'd0, busy}, 32'd0);
        check_state("glitch");

        // bad stop bit
        send_frame(8'h3C, 1, 1'b0, 8'h00, -1, 10);
        model_frame(8'h3C, 1'b0);
        check_state("ferr");

        // bad stop bit followed by a held break: no further activity
        send_frame(8'h5A, 1, 1'b0, 8'h00, -1, 0);
        model_frame(8'h5A, 1'b0);
        RxD = 1'b0;
        repeat (1000) begin
            @(posedge clk);
            #1;
        end
        check("break_busy", {31'd0, busy}, 32'd0);
        check_state("break");
        idle(20);

        // reset inside data bit 4; remaining bits and stop are high so no new edge follows
        send_frame(8'hF5, 1, 1'b1, 8'h00, 4, 10);
        exp_data = 8'h00;
        check_state("rstframe");
        send_frame(8'h81, 1, 1'b1, 8'h00, -1, 10);
        model_frame(8'h81, 1'b1);
        check_state("f81");

        // one-clock spikes at sample points of 0x96
`ifdef RX_MAJORITY_VOTE_EN
        send_frame(8'h96, 1, 1'b1, 8'hFF, -1, 10);
        model_frame(8'h96, 1'b1);
`else
        send_frame(8'h96, 1, 1'b1, 8'h01, -1, 10);
        model_frame(8'h97, 1'b1);
`endif
        check_state("spike");

        // randomized frames
        for (int i = 0; i < 8; i++) begin
            b   = 8'($urandom);
            ns  = int'($urandom_range(1, 2));
            sv  = ($urandom_range(0, 4) != 0);
            gap = int'($urandom_range(0, 20));
            if (!sv && gap < 2) gap = 2;
            send_frame(b, ns, sv, 8'h00, -1, gap);
            model_frame(b, sv);
            check_state($sformatf("rnd%0d", i));
        end

        idle(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
